// File: rtl/loader_mem_writer_pkg.sv
// Shared encodings and defaults for the boot loader memory writer.
package loader_mem_writer_pkg;
    typedef enum logic [7:0] {
        CS_IDLE   = 8'd0,
        CS_CAPT   = 8'd1,
        CS_WAITLO = 8'd2,
        CS_FULL   = 8'd3
    } ctrl_state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] DEF_MAX_WORDS = 32'h0040_0000;
endpackage

// File: rtl/loader_mem_writer_wfifo.sv
// Synchronous show-ahead word FIFO between the loader handshake and memory port.
module loader_wfifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk27mhz,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk27mhz) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk27mhz) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/loader_mem_writer.sv
// Buffers the SD loader word stream and writes it sequentially to main memory,
// tracking word count, additive checksum, overflow and completion.
module loader_mem_writer
    import loader_mem_writer_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
    parameter int                FIFO_DEPTH = 8,
    parameter logic [31:0]       MAX_WORDS  = DEF_MAX_WORDS
) (
    input  logic              clk27mhz,
    input  logic              reset,
    input  logic [31:0]       i_data,
    input  logic              i_we,
    input  logic              i_done,
    output logic [7:0]        o_ctrl_state,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_wstrb,
    input  logic              i_mem_ack,
    output logic [31:0]       o_word_count,
    output logic [31:0]       o_checksum,
    output logic              o_err,
    output logic              o_done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ctrl_state_e       state, state_nxt;
    logic              take, push, over, pop;
    logic              full, empty;
    logic [31:0]       fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       accepted;

    loader_wfifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk27mhz (clk27mhz),
        .reset    (reset),
        .push     (push),
        .wdata    (i_data),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    // A word is taken exactly once on the IDLE->CAPT transition; full blocks it.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            CS_IDLE: begin
                if (i_we && !full) begin
                    take      = 1'b1;
                    state_nxt = CS_CAPT;
                end
            end
            CS_CAPT:   state_nxt = CS_WAITLO;
            CS_WAITLO: if (!i_we) state_nxt = CS_IDLE;
            default:   state_nxt = CS_IDLE;
        endcase
    end

    // After done or past the word limit the handshake still completes but data is dropped.
    assign over = take && !o_done && (accepted == MAX_WORDS);
    assign push = take && !o_done && (accepted != MAX_WORDS);
    assign pop  = !o_mem_req && !empty;

    assign o_ctrl_state = full ? CS_FULL : state;
    assign o_mem_wstrb  = o_mem_req ? 4'hF : 4'h0;

    always_ff @(posedge clk27mhz) begin
        if (reset) begin
            state        <= CS_IDLE;
            accepted     <= '0;
            o_mem_req    <= 1'b0;
            o_mem_addr   <= BASE_ADDR;
            o_mem_wdata  <= '0;
            o_word_count <= '0;
            o_checksum   <= '0;
            o_err        <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) accepted <= accepted + 32'd1;
            if (over) o_err <= 1'b1;
            if (pop) begin
                o_mem_req   <= 1'b1;
                o_mem_wdata <= fifo_rdata;
            end else if (o_mem_req && i_mem_ack) begin
                o_mem_req    <= 1'b0;
                o_mem_addr   <= o_mem_addr + ADDR_W'(4);
                o_word_count <= o_word_count + 32'd1;
                o_checksum   <= o_checksum + o_mem_wdata;
            end
            if (i_done && fifo_count == '0 && !o_mem_req && state == CS_IDLE && !take)
                o_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_loader_mem_writer.sv
// Scoreboard bench: loader stimulus pushes expected writes, a monitor checks every acked request.
module tb_loader_mem_writer;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_data = '0;
    logic        i_we = 1'b0;
    logic        i_done = 1'b0;
    logic [7:0]  o_ctrl_state;
    logic        o_mem_req;
    logic [31:0] o_mem_addr, o_mem_wdata, o_word_count, o_checksum;
    logic [3:0]  o_mem_wstrb;
    logic        mem_ack;
    logic        o_err, o_done;

    logic [31:0] data2 = '0;
    logic        we2 = 1'b0;
    logic [7:0]  ctrl2;
    logic        req2, err2, done2;
    logic [31:0] addr2, wdata2, wc2, cs2;
    logic [3:0]  wstrb2;

    int total = 0;
    int bad = 0;
    int ack_delay = 0;
    bit ack_hold = 0;
    int wcnt = 0;
    int n2 = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] exp_addr = BASE;

    always #5 clk = ~clk;

    loader_mem_writer dut (
        .clk27mhz(clk), .reset(reset), .i_data(i_data), .i_we(i_we), .i_done(i_done),
        .o_ctrl_state(o_ctrl_state), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_ack(mem_ack),
        .o_word_count(o_word_count), .o_checksum(o_checksum), .o_err(o_err), .o_done(o_done)
    );

    loader_mem_writer #(.MAX_WORDS(32'd4)) u_ovf (
        .clk27mhz(clk), .reset(reset), .i_data(data2), .i_we(we2), .i_done(1'b0),
        .o_ctrl_state(ctrl2), .o_mem_req(req2), .o_mem_addr(addr2),
        .o_mem_wdata(wdata2), .o_mem_wstrb(wstrb2), .i_mem_ack(req2),
        .o_word_count(wc2), .o_checksum(cs2), .o_err(err2), .o_done(done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory slave: acks after ack_delay cycles of request, unless held off.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset || !o_mem_req || mem_ack) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (!ack_hold && wcnt >= ack_delay) mem_ack = 1'b1;
            else wcnt++;
        end
    end

    always @(negedge clk) begin
        if (!reset && o_mem_req && mem_ack) begin
            if (q_addr.size() == 0) begin
                chk("unexpected write", o_mem_wdata, 32'hFFFF_FFFF ^ o_mem_wdata);
            end else begin
                chk("wr addr", o_mem_addr, q_addr.pop_front());
                chk("wr data", o_mem_wdata, q_data.pop_front());
                chk("wr strb", {28'b0, o_mem_wstrb}, 32'hF);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) n2 = 0;
        else if (req2) n2++;
    end

    task automatic wait_ctrl(input bit inst, input bit nz, output bit ok);
        logic [7:0] cur;
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            cur = inst ? ctrl2 : o_ctrl_state;
            if ((cur != 8'd0) == nz) begin
                ok = 1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input int hold, input bit exp);
        bit ok;
        wait_ctrl(0, 0, ok);
        if (!ok) chk("ready timeout", 32'd0, 32'd1);
        i_data = d;
        i_we = 1'b1;
        if (exp) begin
            q_addr.push_back(exp_addr);
            q_data.push_back(d);
            exp_addr += 32'd4;
        end
        wait_ctrl(0, 1, ok);
        if (!ok) chk("busy timeout", 32'd0, 32'd1);
        repeat (hold) begin @(posedge clk); #1; end
        i_we = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if (q_addr.size() == 0 && !o_mem_req) begin ok = 1; break; end
        end
        chk("drain", {31'b0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_we = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        q_addr.delete();
        q_data.delete();
        exp_addr = BASE;
    endtask

    initial begin
        bit ok;
        int stuck, last, cyc;
        logic [31:0] wc_snap;

        repeat (2) begin @(posedge clk); #1; end
        chk("rst ctrl", {24'b0, o_ctrl_state}, 32'd0);
        chk("rst req", {31'b0, o_mem_req}, 32'd0);
        chk("rst addr", o_mem_addr, BASE);
        chk("rst wdata", o_mem_wdata, 32'd0);
        chk("rst strb", {28'b0, o_mem_wstrb}, 32'd0);
        chk("rst cnt", o_word_count, 32'd0);
        chk("rst sum", o_checksum, 32'd0);
        chk("rst err/done", {30'b0, o_err, o_done}, 32'd0);
        reset = 1'b0;

        // single word, ctrl sequence 0->1->2->0
        ack_delay = 2;
        i_data = 32'hDEADBEEF;
        i_we = 1'b1;
        q_addr.push_back(exp_addr); q_data.push_back(32'hDEADBEEF); exp_addr += 32'd4;
        @(posedge clk); #1; chk("t1 ctrl capt", {24'b0, o_ctrl_state}, 32'd1);
        @(posedge clk); #1; chk("t1 ctrl waitlo", {24'b0, o_ctrl_state}, 32'd2);
        i_we = 1'b0;
        @(posedge clk); #1; chk("t1 ctrl idle", {24'b0, o_ctrl_state}, 32'd0);
        drain();
        chk("t1 count", o_word_count, 32'd1);
        chk("t1 sum", o_checksum, 32'hDEADBEEF);
        chk("t1 next addr", o_mem_addr, 32'h8000_0004);

        // 128-word sector from a fresh reset, WE held long on odd words
        do_reset();
        ack_delay = 0;
        for (int i = 0; i < 128; i++) send_word(i, (i % 2) ? 5 : 0, 1);
        drain();
        chk("t2 count", o_word_count, 32'd128);
        chk("t2 sum", o_checksum, 32'd8128);
        chk("t2 addr", o_mem_addr, 32'h8000_0200);

        // backpressure: one word in the request register plus eight buffered
        ack_hold = 1;
        wc_snap = o_word_count;
        for (int i = 0; i < 8; i++) send_word(32'hA000_0000 + i, 0, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("t3 not full at 7", {24'b0, o_ctrl_state}, 32'd0);
        send_word(32'hA000_0008, 0, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("t3 full state", {24'b0, o_ctrl_state}, 32'd3);
        i_data = 32'hA000_0009;
        i_we = 1'b1;
        q_addr.push_back(exp_addr); q_data.push_back(32'hA000_0009); exp_addr += 32'd4;
        stuck = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (o_ctrl_state != 8'd3) stuck++;
        end
        chk("t3 held full", stuck, 32'd0);
        chk("t3 no writes", o_word_count, wc_snap);
        ack_hold = 0;
        wait_ctrl(0, 0, ok); chk("t3 reopen", {31'b0, ok}, 32'd1);
        wait_ctrl(0, 1, ok); chk("t3 late capt", {31'b0, ok}, 32'd1);
        i_we = 1'b0;
        for (int i = 10; i < 15; i++) send_word(32'hA000_0000 + i, 1, 1);
        drain();
        chk("t3 count", o_word_count, wc_snap + 32'd15);

        // done ordering with words still buffered
        ack_delay = 4;
        wc_snap = o_word_count;
        for (int i = 0; i < 4; i++) send_word(32'hC000_0000 + i, 0, 1);
        i_done = 1'b1;
        last = -100;
        cyc = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            cyc = n;
            if (o_mem_req && mem_ack) last = n;
            if (o_done) break;
        end
        chk("t4 done seen", {31'b0, o_done}, 32'd1);
        chk("t4 done latency", cyc - last, 32'd2);
        chk("t4 count", o_word_count, wc_snap + 32'd4);
        chk("t4 sb empty", q_addr.size(), 32'd0);
        @(posedge clk); #1;
        send_word(32'h5555_5555, 0, 0);
        repeat (10) begin @(posedge clk); #1; end
        chk("t4 discard", o_word_count, wc_snap + 32'd4);
        chk("t4 sticky done", {31'b0, o_done}, 32'd1);

        // reset with a request pending and data buffered
        i_done = 1'b0;
        do_reset();
        ack_hold = 1;
        for (int i = 0; i < 3; i++) send_word(32'hE000_0000 + i, 0, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("t5 req before", {31'b0, o_mem_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5 req", {31'b0, o_mem_req}, 32'd0);
        chk("t5 addr", o_mem_addr, BASE);
        chk("t5 count", o_word_count, 32'd0);
        chk("t5 sum", o_checksum, 32'd0);
        chk("t5 ctrl", {24'b0, o_ctrl_state}, 32'd0);
        reset = 1'b0;
        q_addr.delete(); q_data.delete(); exp_addr = BASE;
        ack_hold = 0;
        stuck = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (o_mem_req) stuck++;
        end
        chk("t5 fifo flushed", stuck, 32'd0);

        // overflow on the MAX_WORDS=4 instance
        for (int k = 1; k <= 6; k++) begin
            wait_ctrl(1, 0, ok); chk("ovf ready", {31'b0, ok}, 32'd1);
            data2 = k;
            we2 = 1'b1;
            wait_ctrl(1, 1, ok); chk("ovf handshake", {31'b0, ok}, 32'd1);
            we2 = 1'b0;
            if (k == 4) begin
                repeat (6) begin @(posedge clk); #1; end
                chk("ovf err early", {31'b0, err2}, 32'd0);
            end
        end
        repeat (10) begin @(posedge clk); #1; end
        chk("ovf writes", n2, 32'd4);
        chk("ovf count", wc2, 32'd4);
        chk("ovf sum", cs2, 32'd10);
        chk("ovf addr", addr2, 32'h8000_0010);
        chk("ovf err", {31'b0, err2}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
